// File: rtl/dcpu16_mem_slv_pkg.sv
// rtl/dcpu16_mem_slv_pkg.sv - shared constants for the dual-port memory responder
// Purpose: port FSM state encodings, data/counter widths and the default address width.
// Ports: none (package).
package dcpu16_mem_slv_pkg;

    localparam int DW         = 16;  // bus data / word width
    localparam int AW_DEFAULT = 8;   // default address bits used by the array
    localparam int CW         = 4;   // wait counter width, covers WAIT 0..15

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_WAIT = 2'd1;
    localparam logic [1:0] MS_ACK  = 2'd2;

endpackage

// File: rtl/dcpu16_mem_slv_if.sv
// rtl/dcpu16_mem_slv_if.sv - one F/G style memory bus (request strobe, write data, read data, ack)
// Purpose: bundles one CPU memory bus; master = CPU side, slave = memory side.
// Signals: adr (word address), stb (request, held until ack), wre (1=write),
//          dti (write data into memory), dto (read data out of memory), ack (one-cycle completion).
interface dcpu16_mem_slv_if;
    import dcpu16_mem_slv_pkg::*;

    logic [DW-1:0] adr;
    logic          stb;
    logic          wre;
    logic [DW-1:0] dti;
    logic [DW-1:0] dto;
    logic          ack;

    modport master (output adr, stb, wre, dti, input dto, ack);
    modport slave  (input adr, stb, wre, dti, output dto, ack);

endinterface

// File: rtl/dcpu16_mem_port.sv
// rtl/dcpu16_mem_port.sv - per-bus request FSM with programmable stall before ack
// Purpose: IDLE/WAIT/ACK sequencing for one bus; issues the capture strobe and the ack pulse.
// Ports: clk, rst (async active-low), stb (request in), cap (capture on this edge), ack (registered pulse).
module dcpu16_mem_port
    import dcpu16_mem_slv_pkg::*;
#(
    parameter int WAIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    output logic cap,
    output logic ack
);

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // Gating with rst keeps a request that coincides with reset assertion from committing.
    assign cap = (state == MS_IDLE) && stb && rst;
    assign ack = (state == MS_ACK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MS_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (stb) begin
                        if (WAIT > 0) begin
                            state <= MS_WAIT;
                            cnt   <= CW'(WAIT - 1);
                        end else begin
                            state <= MS_ACK;
                        end
                    end
                end
                MS_WAIT: begin
                    // Initiator abandoning the request cancels the ack only.
                    if (!stb) begin
                        state <= MS_IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= MS_ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // stb is still the old request here, so it is deliberately ignored.
                MS_ACK:  state <= MS_IDLE;
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dcpu16_mem_slv.sv
// rtl/dcpu16_mem_slv.sv - dual-port on-chip RAM serving the CPU F bus and G bus
// Purpose: storage array, write-priority merge and read data registers behind two port FSMs.
// Ports: clk, rst (async active-low), f_bus / g_bus (slave side of dcpu16_mem_slv_if).
module dcpu16_mem_slv
    import dcpu16_mem_slv_pkg::*;
#(
    parameter int AW     = AW_DEFAULT,
    parameter int WAIT_F = 0,
    parameter int WAIT_G = 0
) (
    input  logic                clk,
    input  logic                rst,
    dcpu16_mem_slv_if.slave     f_bus,
    dcpu16_mem_slv_if.slave     g_bus
);

    logic [DW-1:0] mem [2**AW];

    logic          f_cap;
    logic          g_cap;
    logic [AW-1:0] f_idx;
    logic [AW-1:0] g_idx;
    logic [DW-1:0] f_dto_q;
    logic [DW-1:0] g_dto_q;
    logic          unused_adr_hi;

    // Upper address bits alias onto the array.
    assign f_idx         = f_bus.adr[AW-1:0];
    assign g_idx         = g_bus.adr[AW-1:0];
    assign unused_adr_hi = ^{f_bus.adr[DW-1:AW], g_bus.adr[DW-1:AW]};

    dcpu16_mem_port #(.WAIT(WAIT_F)) u_f_port (
        .clk (clk),
        .rst (rst),
        .stb (f_bus.stb),
        .cap (f_cap),
        .ack (f_bus.ack)
    );

    dcpu16_mem_port #(.WAIT(WAIT_G)) u_g_port (
        .clk (clk),
        .rst (rst),
        .stb (g_bus.stb),
        .cap (g_cap),
        .ack (g_bus.ack)
    );

    // F wins a same-address double write; G's write is simply dropped.
    always_ff @(posedge clk) begin
        if (g_cap && g_bus.wre && !(f_cap && f_bus.wre && (f_idx == g_idx)))
            mem[g_idx] <= g_bus.dti;
        if (f_cap && f_bus.wre)
            mem[f_idx] <= f_bus.dti;
    end

    // Reads sample the pre-edge array contents, giving read-before-write on collisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_dto_q <= '0;
            g_dto_q <= '0;
        end else begin
            if (f_cap && !f_bus.wre)
                f_dto_q <= mem[f_idx];
            if (g_cap && !g_bus.wre)
                g_dto_q <= mem[g_idx];
        end
    end

    assign f_bus.dto = f_dto_q;
    assign g_bus.dto = g_dto_q;

endmodule

// File: tb/tb_dcpu16_mem_slv.sv
// tb/tb_dcpu16_mem_slv.sv - self-checking bench for dcpu16_mem_slv (WAIT_F=0, WAIT_G=3, AW=8)
module tb_dcpu16_mem_slv;

    localparam int WF = 0;
    localparam int WG = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcpu16_mem_slv_if f_bus ();
    dcpu16_mem_slv_if g_bus ();

    dcpu16_mem_slv #(.AW(8), .WAIT_F(WF), .WAIT_G(WG)) dut (
        .clk   (clk),
        .rst   (rst),
        .f_bus (f_bus),
        .g_bus (g_bus)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] mm [256];
    logic [15:0] last_f;
    logic [15:0] last_g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer on F and/or G issued on the same sampling edge; expectations from the word model.
    task automatic xfer(input bit fe, input bit fw, input logic [15:0] fa, input logic [15:0] fd,
                        input bit ge, input bit gw, input logic [15:0] ga, input logic [15:0] gd);
        int fi;
        int gi;
        logic [15:0] fexp;
        logic [15:0] gexp;
        bit fdone;
        bit gdone;
        fi = int'(fa) % 256;
        gi = int'(ga) % 256;
        if (fe && !fw) last_f = mm[fi];
        if (ge && !gw) last_g = mm[gi];
        fexp = last_f;
        gexp = last_g;
        if (ge && gw) mm[gi] = gd;
        if (fe && fw) mm[fi] = fd;
        @(negedge clk);
        f_bus.adr = fa; f_bus.wre = fw; f_bus.dti = fd; f_bus.stb = fe;
        g_bus.adr = ga; g_bus.wre = gw; g_bus.dti = gd; g_bus.stb = ge;
        fdone = !fe;
        gdone = !ge;
        for (int c = 1; c <= 24; c++) begin
            if (fdone && gdone) break;
            @(posedge clk); #1;
            if (!fdone && f_bus.ack) begin
                check("f_latency", c, WF + 1);
                check("f_dto", f_bus.dto, fexp);
                f_bus.stb = 1'b0;
                fdone = 1'b1;
            end
            if (!gdone && g_bus.ack) begin
                check("g_latency", c, WG + 1);
                check("g_dto", g_bus.dto, gexp);
                g_bus.stb = 1'b0;
                gdone = 1'b1;
            end
        end
        check("f_ack_seen", fdone, 1);
        check("g_ack_seen", gdone, 1);
        f_bus.stb = 1'b0;
        g_bus.stb = 1'b0;
        @(posedge clk); #1;
        check("f_ack_pulse", f_bus.ack, 0);
        check("g_ack_pulse", g_bus.ack, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int          n;
        logic [15:0] a;
        logic [15:0] b;

        // Reset held with both strobes high: nothing may happen.
        rst = 1'b0;
        f_bus.adr = 16'h0000; f_bus.wre = 1'b1; f_bus.dti = 16'h0000; f_bus.stb = 1'b1;
        g_bus.adr = 16'h0001; g_bus.wre = 1'b1; g_bus.dti = 16'h0000; g_bus.stb = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_f_ack", f_bus.ack, 0);
            check("rst_g_ack", g_bus.ack, 0);
            check("rst_f_dto", f_bus.dto, 16'h0000);
            check("rst_g_dto", g_bus.dto, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rel_f_ack", f_bus.ack, 1);
        f_bus.stb = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rel_g_ack_early", g_bus.ack, 0);
        @(posedge clk); #1;
        check("rel_g_ack", g_bus.ack, 1);
        check("rel_f_dto_hold", f_bus.dto, 16'h0000);
        g_bus.stb = 1'b0;
        @(posedge clk); #1;
        last_f = 16'h0000;
        last_g = 16'h0000;

        // Preload every word through both ports.
        for (int i = 0; i < 128; i++)
            xfer(1'b1, 1'b1, 16'(i), 16'($urandom), 1'b1, 1'b1, 16'(i + 128), 16'($urandom));

        // F write then read with zero wait, then back-to-back reads at full rate.
        xfer(1'b1, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
        xfer(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        f_bus.adr = 16'h0012; f_bus.wre = 1'b0; f_bus.stb = 1'b1;
        n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (f_bus.ack) begin
                n++;
                check("thru_f_dto", f_bus.dto, 16'hBEEF);
            end
        end
        f_bus.stb = 1'b0;
        check("thru_f_count", n, 5);
        @(posedge clk); #1;

        // G read with WAIT_G=3, then a read abandoned in WAIT.
        xfer(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0012, 16'h0000);
        @(negedge clk);
        g_bus.adr = 16'h0020; g_bus.wre = 1'b0; g_bus.stb = 1'b1;
        last_g = mm[32];
        repeat (2) @(posedge clk);
        #1 g_bus.stb = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (g_bus.ack) seen = 1'b1;
        end
        check("drop_no_ack", seen, 0);
        check("drop_g_dto", g_bus.dto, mm[32]);
        // Abandoned write still commits; the port must be back in IDLE.
        @(negedge clk);
        g_bus.adr = 16'h0030; g_bus.wre = 1'b1; g_bus.dti = 16'hABCD; g_bus.stb = 1'b1;
        mm[48] = 16'hABCD;
        repeat (2) @(posedge clk);
        #1 g_bus.stb = 1'b0;
        repeat (3) @(posedge clk);
        xfer(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000);

        // Same-edge collisions.
        xfer(1'b1, 1'b1, 16'h0005, 16'h1111, 1'b1, 1'b1, 16'h0005, 16'h2222);
        xfer(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("coll_ww_model", last_f, 16'h1111);
        xfer(1'b1, 1'b1, 16'h0007, 16'h5555, 1'b0, 1'b0, 16'h0000, 16'h0000);
        xfer(1'b1, 1'b1, 16'h0007, 16'hAAAA, 1'b1, 1'b0, 16'h0007, 16'h0000);
        check("coll_rw_old", g_bus.dto, 16'h5555);

        // Address aliasing.
        xfer(1'b1, 1'b1, 16'h0103, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000);
        xfer(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("alias_read", f_bus.dto, 16'h1234);

        // Reset during a G WAIT after the write was captured.
        @(negedge clk);
        g_bus.adr = 16'h0040; g_bus.wre = 1'b1; g_bus.dti = 16'h7777; g_bus.stb = 1'b1;
        mm[64] = 16'h7777;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_f_dto", f_bus.dto, 16'h0000);
        check("midrst_g_dto", g_bus.dto, 16'h0000);
        g_bus.stb = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (g_bus.ack || f_bus.ack) seen = 1'b1;
        end
        check("midrst_no_ack", seen, 0);
        @(negedge clk);
        rst = 1'b1;
        last_f = 16'h0000;
        last_g = 16'h0000;
        xfer(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0041, 16'h0101);
        xfer(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("midrst_kept", f_bus.dto, 16'h7777);

        // Randomized mixed traffic with frequent aliased collisions.
        for (int i = 0; i < 60; i++) begin
            bit fe;
            bit ge;
            fe = 1'($urandom);
            ge = 1'($urandom);
            if (!fe && !ge) fe = 1'b1;
            a = (16'($urandom) & 16'hFF00) | 16'($urandom_range(0, 7));
            b = (16'($urandom) & 16'hFF00) | 16'($urandom_range(0, 7));
            xfer(fe, 1'($urandom), a, 16'($urandom), ge, 1'($urandom), b, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
